// File: rtl/tube_scan_ctrl.sv
// Avalon-MM multiplexed 7-segment tube scanner with dead-time blanking and frame IRQ.
// Define TUBE_SCAN_HEXDEC_EN to add the CTRL.DECODE hex-to-7-segment path.
module tube_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SEG_W      = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int DEAD_CYC   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  irq,
    output logic [NUM_DIGITS-1:0] tube_en,
    output logic [SEG_W-1:0]      seg_out
);

    logic                  wr;
    logic                  scan_en;
    logic                  blank;
    logic                  irq_en;
    logic                  decode;
    logic [NUM_DIGITS-1:0] mask;
    logic [15:0]           div;
    logic                  frame_done;
    logic [SEG_W-1:0]      dig [NUM_DIGITS];
    logic [15:0]           cnt;
    logic [2:0]            idx;
    logic [15:0]           div_eff;
    logic [SEG_W-1:0]      dig_cur;
    logic                  mask_cur;
    logic [SEG_W-1:0]      seg_val;
    logic                  div_wr;
    logic                  slot_end;
    logic                  last;
    logic                  fd_set;
    logic                  fd_clr;
    logic                  unused;

    assign wr       = chipselect & ~write_n;
    assign div_wr   = wr && (address == 4'd2);
    assign div_eff  = (div < 16'(DEAD_CYC)) ? 16'(DEAD_CYC) : div;
    assign slot_end = (cnt >= div_eff);
    assign last     = (idx == 3'(NUM_DIGITS - 1));
    assign fd_set   = scan_en && !div_wr && slot_end && last;
    assign fd_clr   = wr && (address == 4'd3) && writedata[0];
    assign irq      = frame_done & irq_en;
    assign unused   = ^writedata[31:16];

    // Loop mux avoids indexing past NUM_DIGITS with the 3-bit idx.
    always_comb begin
        dig_cur  = '0;
        mask_cur = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == 3'(i)) begin
                dig_cur  = dig[i];
                mask_cur = mask[i];
            end
        end
    end

`ifdef TUBE_SCAN_HEXDEC_EN
    logic [7:0] cur8;
    logic [6:0] hex7;

    assign cur8 = 8'(dig_cur);

    always_comb begin
        hex7 = 7'h00;
        case (cur8[3:0])
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    end

    assign seg_val = decode ? SEG_W'({cur8[7], hex7}) : dig_cur;
`else
    assign decode  = 1'b0;
    assign seg_val = dig_cur;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_en    <= 1'b0;
            blank      <= 1'b0;
            irq_en     <= 1'b0;
`ifdef TUBE_SCAN_HEXDEC_EN
            decode     <= 1'b0;
`endif
            mask       <= '1;
            div        <= 16'(SCAN_DIV - 1);
            frame_done <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) dig[i] <= '0;
            cnt        <= '0;
            idx        <= '0;
            tube_en    <= '1;
            seg_out    <= '1;
        end else begin
            if (wr && (address == 4'd0)) begin
                scan_en <= writedata[0];
                blank   <= writedata[1];
                irq_en  <= writedata[3];
`ifdef TUBE_SCAN_HEXDEC_EN
                decode  <= writedata[2];
`endif
            end
            if (wr && (address == 4'd1)) mask <= writedata[NUM_DIGITS-1:0];
            if (div_wr) div <= writedata[15:0];
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr && (address == 4'(8 + i))) dig[i] <= writedata[SEG_W-1:0];
            end

            // A DIV write restarts the current slot from its dark phase.
            if (!scan_en) begin
                cnt <= '0;
                idx <= '0;
            end else if (div_wr) begin
                cnt <= '0;
            end else if (slot_end) begin
                cnt <= '0;
                idx <= last ? 3'd0 : idx + 3'd1;
            end else begin
                cnt <= cnt + 16'd1;
            end

            if (fd_set)      frame_done <= 1'b1;
            else if (fd_clr) frame_done <= 1'b0;

            if (!scan_en) begin
                tube_en <= '1;
                seg_out <= '1;
            end else begin
                seg_out <= ~seg_val;
                if ((cnt >= 16'(DEAD_CYC)) && mask_cur && !blank)
                    tube_en <= ~(NUM_DIGITS'(1) << idx);
                else
                    tube_en <= '1;
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            4'd0: readdata = {28'd0, irq_en, decode, blank, scan_en};
            4'd1: readdata = 32'(mask);
            4'd2: readdata = {16'd0, div};
            4'd3: readdata = {25'd0, idx, 3'd0, frame_done};
            default: ;
        endcase
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (address == 4'(8 + i)) readdata = 32'(dig[i]);
        end
    end

endmodule

// File: tb/tb_tube_scan_ctrl.sv
// Directed bench for tube_scan_ctrl: reset, scan timing, frame flag, mask/blank, DIV, decode.
module tb_tube_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [3:0]  tube_en;
    logic [7:0]  seg_out;

    int checks   = 0;
    int failures = 0;
    logic [31:0] v;

    tube_scan_ctrl #(
        .NUM_DIGITS(4),
        .SEG_W     (8),
        .SCAN_DIV  (10),
        .DEAD_CYC  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .tube_en   (tube_en),
        .seg_out   (seg_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the write is captured on the next posedge.
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) @(negedge clk);

        chk("rst_tube", 32'(tube_en), 32'hF);
        chk("rst_seg", 32'(seg_out), 32'hFF);
        chk("rst_irq", 32'(irq), 32'h0);
        rd(4'd1, v); chk("rst_mask", v, 32'hF);
        rd(4'd2, v); chk("rst_div", v, 32'd9);
        rd(4'd5, v); chk("unmapped", v, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) wr(4'(8 + i), 32'(1 << i));
        rd(4'd10, v); chk("dig2_rd", v, 32'h04);
        wr(4'd0, 32'h1);
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            chk($sformatf("scan_tube_%0d", j), 32'(tube_en),
                (j % 10 < 2) ? 32'hF : 32'(4'(~(4'd1 << (j / 10)))));
            chk($sformatf("scan_seg_%0d", j), 32'(seg_out),
                32'(8'(~(8'd1 << (j / 10)))));
        end

        rd(4'd3, v); chk("fd_after_wrap", v, 32'h01);
        chk("irq_off", 32'(irq), 32'h0);
        wr(4'd0, 32'h9);
        chk("irq_on", 32'(irq), 32'h1);
        wr(4'd3, 32'h1);
        chk("irq_w1c", 32'(irq), 32'h0);

        wr(4'd0, 32'h0);
        wr(4'd3, 32'h1);
        wr(4'd0, 32'h9);
        repeat (39) @(negedge clk);
        rd(4'd3, v); chk("pre_wrap_stat", v, 32'h30);
        wr(4'd3, 32'h1);
        rd(4'd3, v); chk("set_wins", v, 32'h01);
        chk("set_wins_irq", 32'(irq), 32'h1);

        wr(4'd0, 32'h0);
        wr(4'd1, 32'h5);
        wr(4'd0, 32'h1);
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            chk($sformatf("mask_tube_%0d", j), 32'(tube_en),
                ((j % 10 >= 2) && ((j / 10) % 2 == 0)) ?
                32'(4'(~(4'd1 << (j / 10)))) : 32'hF);
        end

        wr(4'd0, 32'h3);
        @(negedge clk);
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            chk($sformatf("blank_%0d", j), 32'(tube_en), 32'hF);
        end

        wr(4'd0, 32'h0);
        wr(4'd1, 32'hF);
        wr(4'd0, 32'h1);
        repeat (4) @(negedge clk);
        chk("pre_dis_tube", 32'(tube_en), 32'hE);
        wr(4'd0, 32'h0);
        @(negedge clk);
        chk("dis_tube", 32'(tube_en), 32'hF);
        chk("dis_seg", 32'(seg_out), 32'hFF);
        rd(4'd3, v); chk("dis_idx", v & 32'h70, 32'h0);

        wr(4'd2, 32'h1);
        rd(4'd2, v); chk("div_rd", v, 32'h1);
        wr(4'd0, 32'h1);
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            chk($sformatf("clamp_tube_%0d", j), 32'(tube_en),
                (j % 3 == 2) ? 32'(4'(~(4'd1 << (j / 3)))) : 32'hF);
            chk($sformatf("clamp_seg_%0d", j), 32'(seg_out),
                32'(8'(~(8'd1 << (j / 3)))));
        end

        wr(4'd0, 32'h0);
        wr(4'd2, 32'd9);
        wr(4'd0, 32'h1);
        repeat (14) @(negedge clk);
        chk("pre_divwr_tube", 32'(tube_en), 32'hD);
        wr(4'd2, 32'd9);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("restart_%0d", k), 32'(tube_en),
                (k < 2) ? 32'hF : 32'hD);
        end
        @(negedge clk);
        chk("restart_next_tube", 32'(tube_en), 32'hF);
        chk("restart_next_seg", 32'(seg_out), 32'hFB);

        wr(4'd0, 32'h0);
        wr(4'd8, 32'h8A);
        wr(4'd0, 32'h5);
        rd(4'd0, v);
`ifdef TUBE_SCAN_HEXDEC_EN
        chk("ctrl_decode_rd", v, 32'h5);
        @(negedge clk);
        chk("decode_seg", 32'(seg_out), 32'h08);
`else
        chk("ctrl_decode_rd", v, 32'h1);
        @(negedge clk);
        chk("raw_seg", 32'(seg_out), 32'h75);
`endif

        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_tube", 32'(tube_en), 32'hF);
        chk("mrst_seg", 32'(seg_out), 32'hFF);
        chk("mrst_irq", 32'(irq), 32'h0);
        rd(4'd0, v); chk("mrst_ctrl", v, 32'h0);
        rd(4'd3, v); chk("mrst_stat", v, 32'h0);
        rd(4'd8, v); chk("mrst_dig0", v, 32'h0);
        rd(4'd2, v); chk("mrst_div", v, 32'd9);
        reset = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
